// File: rtl/kernel_cc_hls_deadlock_report_ctrl.sv
// kernel_cc_hls_deadlock_report_ctrl: confirms a persistent deadlock candidate, launches
// the report token from a round-robin origin, tracks it and holds a sticky report.
`default_nettype none

module kernel_cc_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID_W      = 2,
    parameter int CONFIRM_CYCLES = 4,
    parameter int TRACE_TIMEOUT  = 64,
    parameter int CNT_W          = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PROC_NUM-1:0]  dl_detect_vec,
    input  logic [PROC_NUM-1:0]  token_active_vec,
    input  logic                 report_ack,
    output logic [PROC_NUM-1:0]  origin_vec,
    output logic                 token_clear,
    output logic                 dl_detect_global,
    output logic                 report_valid,
    output logic [PROC_ID_W-1:0] report_proc_id,
    output logic [PROC_NUM-1:0]  report_mask,
    output logic                 report_timeout,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONFIRM = 3'd1,
        S_ORIGIN  = 3'd2,
        S_TRACE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [PROC_ID_W:0] NUM_W     = (PROC_ID_W+1)'(PROC_NUM);
    localparam logic [CNT_W-1:0]   CONF_LIM  = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0]   TRACE_LIM = CNT_W'(TRACE_TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [PROC_ID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [PROC_ID_W-1:0] sel, sel_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [PROC_NUM-1:0]  mask, mask_nxt;

    logic [PROC_NUM-1:0]  origin_nxt;
    logic                 token_clear_nxt;
    logic                 global_nxt;
    logic                 valid_nxt;
    logic [PROC_ID_W-1:0] proc_id_nxt;
    logic [PROC_NUM-1:0]  rmask_nxt;
    logic                 timeout_nxt;

    logic [PROC_ID_W-1:0] pick;
    logic                 found;
    logic [PROC_ID_W:0]   idx;
    logic [PROC_ID_W:0]   sel_inc;
    logic [PROC_NUM-1:0]  sel_onehot;
    logic [PROC_NUM-1:0]  mask_upd;

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            idx = {1'b0, rr_ptr} + (PROC_ID_W+1)'(i);
            if (idx >= NUM_W) begin
                idx = idx - NUM_W;
            end
            if (!found && dl_detect_vec[idx[PROC_ID_W-1:0]]) begin
                pick  = idx[PROC_ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_inc = {1'b0, sel} + 1'b1;
        if (sel_inc >= NUM_W) begin
            sel_inc = '0;
        end
        sel_onehot = PROC_NUM'(1) << sel;
        mask_upd   = mask | token_active_vec;
    end

    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        sel_nxt         = sel;
        cnt_nxt         = cnt;
        mask_nxt        = mask;
        origin_nxt      = '0;
        token_clear_nxt = 1'b0;
        global_nxt      = dl_detect_global;
        valid_nxt       = report_valid;
        proc_id_nxt     = report_proc_id;
        rmask_nxt       = report_mask;
        timeout_nxt     = report_timeout;

        case (state)
            S_IDLE: begin
                if (|dl_detect_vec) begin
                    sel_nxt   = pick;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (!dl_detect_vec[sel]) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CONF_LIM) begin
                    origin_nxt = sel_onehot;
                    global_nxt = 1'b1;
                    mask_nxt   = sel_onehot;
                    cnt_nxt    = '0;
                    state_nxt  = S_ORIGIN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ORIGIN: begin
                state_nxt = S_TRACE;
            end
            S_TRACE: begin
                mask_nxt = mask_upd;
                cnt_nxt  = cnt + 1'b1;
                // The origin's own detect is still high on the first cycle; skip it.
                if ((cnt != '0 && dl_detect_vec[sel]) || cnt == TRACE_LIM) begin
                    token_clear_nxt = 1'b1;
                    timeout_nxt     = !(cnt != '0 && dl_detect_vec[sel]);
                    valid_nxt       = 1'b1;
                    proc_id_nxt     = sel;
                    rmask_nxt       = mask_upd;
                    state_nxt       = S_DONE;
                end
            end
            S_DONE: begin
                if (report_ack) begin
                    valid_nxt   = 1'b0;
                    global_nxt  = 1'b0;
                    timeout_nxt = 1'b0;
                    proc_id_nxt = '0;
                    rmask_nxt   = '0;
                    rr_ptr_nxt  = sel_inc[PROC_ID_W-1:0];
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            rr_ptr           <= '0;
            sel              <= '0;
            cnt              <= '0;
            mask             <= '0;
            origin_vec       <= '0;
            token_clear      <= 1'b0;
            dl_detect_global <= 1'b0;
            report_valid     <= 1'b0;
            report_proc_id   <= '0;
            report_mask      <= '0;
            report_timeout   <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nxt;
            rr_ptr           <= rr_ptr_nxt;
            sel              <= sel_nxt;
            cnt              <= cnt_nxt;
            mask             <= mask_nxt;
            origin_vec       <= origin_nxt;
            token_clear      <= token_clear_nxt;
            dl_detect_global <= global_nxt;
            report_valid     <= valid_nxt;
            report_proc_id   <= proc_id_nxt;
            report_mask      <= rmask_nxt;
            report_timeout   <= timeout_nxt;
            busy             <= (state_nxt != S_IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kernel_cc_hls_deadlock_report_ctrl.sv
// Bench for kernel_cc_hls_deadlock_report_ctrl: scenario tasks checked against a
// report-level model (round-robin pick, trace end time, visited mask).
`default_nettype none

module tb_kernel_cc_hls_deadlock_report_ctrl;

    localparam int PROC_NUM       = 4;
    localparam int PROC_ID_W      = 2;
    localparam int CONFIRM_CYCLES = 4;
    localparam int TRACE_TIMEOUT  = 64;
    localparam int CNT_W          = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [PROC_NUM-1:0]  dl_detect_vec;
    logic [PROC_NUM-1:0]  token_active_vec;
    logic                 report_ack;
    logic [PROC_NUM-1:0]  origin_vec;
    logic                 token_clear;
    logic                 dl_detect_global;
    logic                 report_valid;
    logic [PROC_ID_W-1:0] report_proc_id;
    logic [PROC_NUM-1:0]  report_mask;
    logic                 report_timeout;
    logic                 busy;

    kernel_cc_hls_deadlock_report_ctrl #(
        .PROC_NUM(PROC_NUM), .PROC_ID_W(PROC_ID_W), .CONFIRM_CYCLES(CONFIRM_CYCLES),
        .TRACE_TIMEOUT(TRACE_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec),
        .token_active_vec(token_active_vec), .report_ack(report_ack),
        .origin_vec(origin_vec), .token_clear(token_clear),
        .dl_detect_global(dl_detect_global), .report_valid(report_valid),
        .report_proc_id(report_proc_id), .report_mask(report_mask),
        .report_timeout(report_timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    initial assert ((2 ** CNT_W) > CONFIRM_CYCLES && (2 ** CNT_W) > TRACE_TIMEOUT)
        else $fatal(1, "FAIL cnt_width: CNT_W=%0d too small", CNT_W);

    int errors = 0;
    int checks = 0;
    int rr_model = 0;
    logic [PROC_NUM-1:0] tok_plan [0:TRACE_TIMEOUT-1];

    function automatic int model_pick(input logic [PROC_NUM-1:0] det, input int rr);
        for (int i = 0; i < PROC_NUM; i++) begin
            if (det[(rr + i) % PROC_NUM]) return (rr + i) % PROC_NUM;
        end
        return 0;
    endfunction

    function automatic logic [14:0] all_outs();
        return {origin_vec, token_clear, dl_detect_global, report_valid, report_proc_id,
                report_mask, report_timeout, busy};
    endfunction

    // One full report: confirm, origin, trace (tokens from tok_plan), done, ack.
    task automatic run_report(input logic [PROC_NUM-1:0] det, input int ret_at,
                              input bit ack_noise, input int hold);
        int sel, t_end;
        bit exp_to;
        logic [PROC_NUM-1:0] exp_mask, onehot;
        sel = model_pick(det, rr_model);
        onehot = PROC_NUM'(1) << sel;
        if (ret_at >= 1 && ret_at < TRACE_TIMEOUT) begin
            t_end = ret_at; exp_to = 1'b0;
        end else begin
            t_end = TRACE_TIMEOUT - 1; exp_to = 1'b1;
        end
        exp_mask = onehot;
        for (int t = 0; t <= t_end; t++) exp_mask |= tok_plan[t];

        dl_detect_vec = det; token_active_vec = '0; report_ack = 1'b0;
        for (int k = 1; k <= CONFIRM_CYCLES; k++) begin
            @(negedge clock);
            checks++;
            if (origin_vec !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL confirm_wait k=%0d: origin=%b busy=%b, want 0000/1", k, origin_vec, busy);
            end
        end
        @(negedge clock);
        checks++;
        if (origin_vec !== onehot || dl_detect_global !== 1'b1) begin
            errors++;
            $display("FAIL origin_pulse: origin=%b global=%b, want %b/1", origin_vec, dl_detect_global, onehot);
        end
        dl_detect_vec = '0;
        @(negedge clock);
        checks++;
        if (origin_vec !== '0) begin
            errors++;
            $display("FAIL origin_width: origin=%b, want 0000", origin_vec);
        end
        for (int t = 0; t <= t_end; t++) begin
            token_active_vec = tok_plan[t];
            dl_detect_vec = (PROC_NUM'($urandom) & ~onehot) | ((t == ret_at) ? onehot : '0);
            report_ack = ack_noise ? 1'($urandom) : 1'b0;
            @(negedge clock);
            if (t < t_end) begin
                checks++;
                if (token_clear !== 1'b0 || report_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL trace_early t=%0d: clear=%b valid=%b, want 0/0", t, token_clear, report_valid);
                end
            end
        end
        report_ack = 1'b0;
        checks++;
        if (token_clear !== 1'b1 || report_valid !== 1'b1 || report_proc_id !== PROC_ID_W'(sel) ||
            report_mask !== exp_mask || report_timeout !== exp_to || dl_detect_global !== 1'b1) begin
            errors++;
            $display("FAIL report: clear=%b valid=%b id=%0d mask=%b to=%b glob=%b, want 1/1/%0d/%b/%b/1",
                     token_clear, report_valid, report_proc_id, report_mask, report_timeout,
                     dl_detect_global, sel, exp_mask, exp_to);
        end
        for (int h = 0; h < hold; h++) begin
            dl_detect_vec = PROC_NUM'($urandom);
            token_active_vec = PROC_NUM'($urandom);
            @(negedge clock);
            checks++;
            if (token_clear !== 1'b0 || report_valid !== 1'b1 || report_proc_id !== PROC_ID_W'(sel) ||
                report_mask !== exp_mask || report_timeout !== exp_to || busy !== 1'b1) begin
                errors++;
                $display("FAIL done_hold h=%0d: clear=%b valid=%b id=%0d mask=%b to=%b busy=%b",
                         h, token_clear, report_valid, report_proc_id, report_mask, report_timeout, busy);
            end
        end
        report_ack = 1'b1; dl_detect_vec = '0; token_active_vec = '0;
        @(negedge clock);
        report_ack = 1'b0;
        checks++;
        if (report_valid !== 1'b0 || dl_detect_global !== 1'b0 || report_timeout !== 1'b0 ||
            busy !== 1'b0 || token_clear !== 1'b0) begin
            errors++;
            $display("FAIL ack: valid=%b glob=%b to=%b busy=%b clear=%b, want all 0",
                     report_valid, dl_detect_global, report_timeout, busy, token_clear);
        end
        rr_model = (sel + 1) % PROC_NUM;
    endtask

    task automatic fill_tokens_random();
        for (int t = 0; t < TRACE_TIMEOUT; t++) tok_plan[t] = PROC_NUM'($urandom) & PROC_NUM'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0; dl_detect_vec = '0; token_active_vec = '0; report_ack = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_state: outs=%h, want 0", all_outs());
        end
        reset = 1'b1;
        rr_model = 0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        for (int t = 0; t < TRACE_TIMEOUT; t++) tok_plan[t] = '0;
        tok_plan[0] = 4'b0010;
        tok_plan[1] = 4'b0100;
        run_report(4'b0001, 2, 1'b0, 2);
    endtask

    task automatic test_glitch();
        dl_detect_vec = 4'b0100;
        repeat (2) @(negedge clock);
        dl_detect_vec = '0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: busy=%b, want 0", busy);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if (origin_vec !== '0 || dl_detect_global !== 1'b0 || report_valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch_quiet k=%0d: origin=%b glob=%b valid=%b", k, origin_vec, dl_detect_global, report_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        for (int n = 0; n < 3; n++) begin
            fill_tokens_random();
            run_report(4'b1010, int'($urandom_range(1, 8)), 1'b0, 1);
        end
    endtask

    task automatic test_timeout();
        fill_tokens_random();
        run_report(4'b0100, -1, 1'b0, 1);
    endtask

    task automatic test_simultaneous();
        fill_tokens_random();
        run_report(4'b0010, TRACE_TIMEOUT - 1, 1'b0, 1);
        fill_tokens_random();
        run_report(4'b1000, int'($urandom_range(1, 10)), 1'b1, 2);
        fill_tokens_random();
        run_report(4'b0001, 0, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [PROC_NUM-1:0] d;
        for (int n = 0; n < 6; n++) begin
            d = PROC_NUM'($urandom);
            if (d == '0) d = 4'b0001;
            fill_tokens_random();
            run_report(d, int'($urandom_range(0, 70)), 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_trace();
        dl_detect_vec = 4'b1000;
        repeat (CONFIRM_CYCLES + 1) @(negedge clock);
        dl_detect_vec = '0;
        token_active_vec = 4'b0110;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL async_reset: outs=%h, want 0", all_outs());
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (token_clear !== 1'b0 || all_outs() !== '0) begin
                errors++;
                $display("FAIL reset_hold k=%0d: outs=%h, want 0", k, all_outs());
            end
        end
        token_active_vec = '0;
        reset = 1'b1;
        rr_model = 0;
        fill_tokens_random();
        run_report(4'b0100, int'($urandom_range(1, 6)), 1'b0, 1);
        fill_tokens_random();
        run_report(4'b1111, int'($urandom_range(1, 6)), 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_random();
        test_reset_mid_trace();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
